// File: rtl/alzette_pkg.sv
// Shared types and constants for the iterative Alzette ARX-box engine.
package alzette_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP_A,
    STEP_B,
    DONE
  } state_t;

  localparam int unsigned ROUNDS_MAX = 4;

  // Element [r] is the rotation for round r.
  localparam logic [3:0][4:0] R1_TAB = {5'd24, 5'd0,  5'd17, 5'd31};
  localparam logic [3:0][4:0] R2_TAB = {5'd16, 5'd31, 5'd17, 5'd24};

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

endpackage

// File: rtl/alzette_half_step.sv
// Combinational Alzette half-round: next (x, y) for STEP_A or STEP_B.
// Inverse datapath is built only when ALZETTE_INV_EN is defined.
module alzette_half_step
  import alzette_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] c_i,
  input  logic [4:0]  rot_i,
  input  logic        step_b_i,
  input  logic        inv_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o
);

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    if (!step_b_i) begin
      x_o = x_i + ror32(y_i, rot_i);
    end else begin
      // y uses x before the constant XOR
      y_o = y_i ^ ror32(x_i, rot_i);
      x_o = x_i ^ c_i;
    end
`ifdef ALZETTE_INV_EN
    if (inv_i) begin
      if (!step_b_i) begin
        x_o = x_i ^ c_i;
        y_o = y_i ^ ror32(x_i ^ c_i, rot_i);
      end else begin
        x_o = x_i - ror32(y_i, rot_i);
        y_o = y_i;
      end
    end
`endif
  end

`ifndef ALZETTE_INV_EN
  logic unused_inv;
  assign unused_inv = inv_i;
`endif

endmodule

// File: rtl/alzette_iter.sv
// Iterative Alzette engine: one half-round per cycle over valid/ready handshakes.
// Optional inverse direction compiled in with ALZETTE_INV_EN.
module alzette_iter
  import alzette_pkg::*;
#(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_inv,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic        busy
);

  if (ROUNDS < 1 || ROUNDS > ROUNDS_MAX) begin : g_bad_rounds
    $error("alzette_iter: ROUNDS must be 1..4");
  end

  localparam logic [1:0] RLAST = 2'(ROUNDS - 1);
`ifdef ALZETTE_INV_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  state_t      state_q;
  logic [31:0] x_q, y_q, c_q;
  logic [1:0]  rnd_q;
  logic        inv_q;

  logic [31:0] x_d, y_d;
  logic        step_b;
  logic [4:0]  rot;
  logic        last_round;
  logic        acc_inv;

  assign step_b     = (state_q == STEP_B);
  // Forward uses R1 then R2; inverse applies them in the opposite step order.
  assign rot        = (step_b ^ inv_q) ? R2_TAB[rnd_q] : R1_TAB[rnd_q];
  assign last_round = inv_q ? (rnd_q == 2'd0) : (rnd_q == RLAST);
  assign acc_inv    = in_inv & INV_EN;

  alzette_half_step u_half_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .c_i      (c_q),
    .rot_i    (rot),
    .step_b_i (step_b),
    .inv_i    (inv_q),
    .x_o      (x_d),
    .y_o      (y_d)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      rnd_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= in_y;
            c_q     <= in_c;
            inv_q   <= acc_inv;
            rnd_q   <= acc_inv ? RLAST : 2'd0;
            state_q <= STEP_A;
          end
        end
        STEP_A: begin
          x_q     <= x_d;
          y_q     <= y_d;
          state_q <= STEP_B;
        end
        STEP_B: begin
          x_q <= x_d;
          y_q <= y_d;
          if (last_round) begin
            state_q <= DONE;
          end else begin
            rnd_q   <= inv_q ? rnd_q - 2'd1 : rnd_q + 2'd1;
            state_q <= STEP_A;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_alzette_iter.sv
// Scoreboard bench for alzette_iter (ROUNDS=4 main instance, ROUNDS=1 side instance).
module tb_alzette_iter;

`ifdef ALZETTE_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        g_resetn;
  logic        in_valid, in_inv;
  logic [31:0] in_x, in_y, in_c;
  logic        in_ready, out_valid, busy;
  logic        out_ready = 1'b1;
  logic [31:0] out_x, out_y;

  logic        v1, in_ready1, out_valid1, busy1;
  logic        rdy1 = 1'b1;
  logic        inv1 = 1'b0;
  logic [31:0] x1, y1, c1, ox1, oy1;

  alzette_iter #(.ROUNDS(4)) u_dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_x(in_x), .in_y(in_y), .in_c(in_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .busy(busy));

  alzette_iter #(.ROUNDS(1)) u_dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(v1), .in_ready(in_ready1),
    .in_inv(inv1), .in_x(x1), .in_y(y1), .in_c(c1), .out_valid(out_valid1),
    .out_ready(rdy1), .out_x(ox1), .out_y(oy1), .busy(busy1));

  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  int n_sent = 0;
  int n_done = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 random
  logic [63:0] exp_q[$];
  longint acc_q[$];
  logic [31:0] last_x, last_y;

  always @(posedge g_clk) cyc <= cyc + 1;

  always @(posedge g_clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (no expected event)", nm);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] v, input int unsigned n);
    return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
  endfunction

  // Reference Alzette: whole rounds with plain modular arithmetic.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] c, input bit inv, input int rounds);
    int unsigned r1[4] = '{31, 17, 0, 24};
    int unsigned r2[4] = '{24, 17, 31, 16};
    if (!inv) begin
      for (int r = 0; r < rounds; r++) begin
        x = x + ror(y, r1[r]);
        y = y ^ ror(x, r2[r]);
        x = x ^ c;
      end
    end else begin
      for (int r = rounds - 1; r >= 0; r--) begin
        x = x ^ c;
        y = y ^ ror(x, r2[r]);
        x = x - ror(y, r1[r]);
      end
    end
    return {x, y};
  endfunction

  // Monitor: latency, hold stability and result comparison.
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] px, py;
  always @(negedge g_clk) begin
    if (out_valid && !pv) begin
      if (acc_q.size() == 0) fail("unexpected_out_valid");
      else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd8);
    end
    if (out_valid && pv && !pr) chk("hold_stable", {out_x, out_y}, {px, py});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("scoreboard_empty");
      else begin
        chk("result", {out_x, out_y}, exp_q.pop_front());
        last_x = out_x;
        last_y = out_y;
        n_done++;
      end
    end
    pv = out_valid;
    pr = out_ready;
    px = out_x;
    py = out_y;
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                      input bit inv);
    int t = 0;
    @(posedge g_clk); #1;
    in_valid = 1'b1; in_x = x; in_y = y; in_c = c; in_inv = inv;
    while (!in_ready && t < 200) begin
      @(posedge g_clk); #1;
      t++;
    end
    if (!in_ready) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge g_clk); #1;
    exp_q.push_back(model(x, y, c, inv & INV, 4));
    acc_q.push_back(cyc);
    n_sent++;
    in_valid = 1'b0;
    in_x = $urandom; in_y = $urandom; in_c = $urandom; in_inv = 1'($urandom);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (n_done < n && t < 3000) begin
      @(posedge g_clk);
      t++;
    end
    if (n_done < n) fail("drain_timeout");
  endtask

  task automatic run1(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                      output int k, output logic [63:0] res);
    @(posedge g_clk); #1;
    v1 = 1'b1; x1 = x; y1 = y; c1 = c;
    @(posedge g_clk); #1;
    v1 = 1'b0; x1 = $urandom; y1 = $urandom; c1 = $urandom;
    k = 0;
    while (!out_valid1 && k < 20) begin
      @(posedge g_clk); #1;
      k++;
    end
    res = {ox1, oy1};
  endtask

  initial begin
    int k;
    int seen;
    logic [63:0] res, bp_exp;
    logic [31:0] fx, fy, rx, ry, rc;

    g_resetn = 1'b0;
    in_valid = 1'b0; in_inv = 1'b0; in_x = '0; in_y = '0; in_c = '0;
    v1 = 1'b0; x1 = '0; y1 = '0; c1 = '0;
    repeat (3) @(posedge g_clk);
    #3 g_resetn = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_xy", {out_x, out_y}, 64'd0);
    chk("rst1_ready_busy", {in_ready1, busy1}, 2'b10);

    // Zero fixpoint
    send(32'h0, 32'h0, 32'h0, 1'b0);
    wait_done(n_sent);
    chk("zero_fixpoint", {last_x, last_y}, 64'd0);

    // Round trip / inverse-disabled behaviour
    send(32'h01234567, 32'h89ABCDEF, 32'hB7E15162, 1'b0);
    wait_done(n_sent);
    fx = last_x; fy = last_y;
    send(fx, fy, 32'hB7E15162, 1'b1);
    wait_done(n_sent);
`ifdef ALZETTE_INV_EN
    chk("round_trip", {last_x, last_y}, 64'h01234567_89ABCDEF);
`else
    chk("inv_disabled", {last_x, last_y}, model(fx, fy, 32'hB7E15162, 1'b0, 4));
`endif

    // Single round instance
    run1(32'h00000001, 32'h0, 32'h80000000, k, res);
    chk("r1_latency", 64'(k), 64'd2);
    chk("r1_result", res, 64'h80000001_00000100);
    for (int i = 0; i < 4; i++) begin
      rx = $urandom; ry = $urandom; rc = $urandom;
      run1(rx, ry, rc, k, res);
      chk("r1_random", res, model(rx, ry, rc, 1'b0, 1));
    end

    // Backpressure
    rdy_mode = 0;
    rx = $urandom; ry = $urandom; rc = $urandom;
    bp_exp = model(rx, ry, rc, 1'b0, 4);
    send(rx, ry, rc, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge g_clk); #2;
      k++;
    end
    if (!out_valid) fail("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #2;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, out_x, out_y}, {1'b1, bp_exp});
      in_valid = 1'(i % 2 == 0); in_x = $urandom; in_y = $urandom; in_c = $urandom;
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    @(posedge g_clk); #2;
    @(posedge g_clk); #2;
    chk("bp_release_ready", {in_ready, out_valid}, 2'b10);
    wait_done(n_sent);

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge g_clk);
    end
    rdy_mode = 1;
    wait_done(n_sent);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset during STEP_B of round 2
    @(posedge g_clk); #1;
    in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_c = $urandom; in_inv = 1'b0;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge g_clk);
    #2;
    chk("mid_busy", busy, 1);
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_state", {in_ready, busy, out_valid}, 3'b100);
    chk("mid_rst_xy", {out_x, out_y}, 64'd0);
    repeat (2) @(posedge g_clk);
    #3 g_resetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge g_clk);
      if (out_valid) seen++;
    end
    chk("mid_no_valid", 64'(seen), 64'd0);
    chk("post_rst_state", {in_ready, busy, out_x, out_y}, {2'b10, 64'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
